// File: rtl/my_matrix_multiplier_example_pkg.sv
// Shared types and sizing helpers for the matrix multiplier loop sequencer.
// Holds the FSM state enum, the default dimension width and the beat layout.
package my_matrix_multiplier_example_pkg;

   localparam int C_DIM_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Offsets must hold up to (2^W-1)^2 - 1, hence twice the dimension width.
   function automatic int off_width(input int dim_width);
      return 2 * dim_width;
   endfunction

   typedef struct packed {
      logic [C_DIM_WIDTH_DEFAULT-1:0]   i;
      logic [C_DIM_WIDTH_DEFAULT-1:0]   j;
      logic [C_DIM_WIDTH_DEFAULT-1:0]   k;
      logic [2*C_DIM_WIDTH_DEFAULT-1:0] a_off;
      logic [2*C_DIM_WIDTH_DEFAULT-1:0] b_off;
      logic [2*C_DIM_WIDTH_DEFAULT-1:0] c_off;
      logic                             first_k;
      logic                             last_k;
   } beat_t;

endpackage

// File: rtl/my_matrix_multiplier_example_wrap_counter.sv
// Loadable up-counter that wraps to zero after reaching a terminal value.
// Cascaded instances form the i/j/k loop nest of the sequencer.
module my_matrix_multiplier_example_wrap_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic [W-1:0] count,
   output logic         is_last,
   output logic         wrap
);

   assign is_last = (count == term);
   assign wrap    = en & is_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= is_last ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/my_matrix_multiplier_example_loop_sequencer.sv
// Walks the (i,j,k) loop nest of C = A*B, one index beat per handshake,
// with incrementally maintained A/B/C element offsets and accumulate flags.
module my_matrix_multiplier_example_loop_sequencer
   import my_matrix_multiplier_example_pkg::*;
#(
   parameter int C_DIM_WIDTH = C_DIM_WIDTH_DEFAULT,
   parameter int C_OFF_WIDTH = off_width(C_DIM_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [C_DIM_WIDTH-1:0] dim_m,
   input  logic [C_DIM_WIDTH-1:0] dim_n,
   input  logic [C_DIM_WIDTH-1:0] dim_k,
   output logic                   busy,
   output logic                   done,
   output logic                   beat_valid,
   input  logic                   beat_ready,
   output logic [C_DIM_WIDTH-1:0] beat_i,
   output logic [C_DIM_WIDTH-1:0] beat_j,
   output logic [C_DIM_WIDTH-1:0] beat_k,
   output logic [C_OFF_WIDTH-1:0] beat_a_off,
   output logic [C_OFF_WIDTH-1:0] beat_b_off,
   output logic [C_OFF_WIDTH-1:0] beat_c_off,
   output logic                   beat_first_k,
   output logic                   beat_last_k
);

   localparam int DW = C_DIM_WIDTH;
   localparam int OW = C_OFF_WIDTH;

   state_t state, state_next;

   logic [DW-1:0] m_term, n_term, k_term;
   logic [OW-1:0] n_step, k_step, row_base;
   logic          hs, load, dims_zero;
   logic          i_last, j_last, k_last;
   logic          i_wrap, j_wrap, k_wrap;

   assign hs        = beat_valid & beat_ready;
   assign load      = (state == IDLE) & start;
   assign dims_zero = (dim_m == '0) | (dim_n == '0) | (dim_k == '0);

   // k is innermost: each outer level only steps when every inner level wraps.
   my_matrix_multiplier_example_wrap_counter #(.W(DW)) u_k_cnt (
      .clk(clk), .rst(rst), .load(load), .load_val('0), .en(hs),
      .term(k_term), .count(beat_k), .is_last(k_last), .wrap(k_wrap)
   );

   my_matrix_multiplier_example_wrap_counter #(.W(DW)) u_j_cnt (
      .clk(clk), .rst(rst), .load(load), .load_val('0), .en(k_wrap),
      .term(n_term), .count(beat_j), .is_last(j_last), .wrap(j_wrap)
   );

   my_matrix_multiplier_example_wrap_counter #(.W(DW)) u_i_cnt (
      .clk(clk), .rst(rst), .load(load), .load_val('0), .en(j_wrap),
      .term(m_term), .count(beat_i), .is_last(i_last), .wrap(i_wrap)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = dims_zero ? DONE : RUN;
         RUN:  if (i_wrap) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         beat_valid <= 1'b0;
      end else begin
         state      <= state_next;
         busy       <= (state_next != IDLE);
         done       <= (state_next == DONE);
         beat_valid <= (state_next == RUN);
      end
   end

   // Offsets advance by adds only; row_base remembers i*K for the a_off rewind.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_term     <= '0;
         n_term     <= '0;
         k_term     <= '0;
         n_step     <= '0;
         k_step     <= '0;
         row_base   <= '0;
         beat_a_off <= '0;
         beat_b_off <= '0;
         beat_c_off <= '0;
      end else if (load) begin
         m_term     <= dim_m - 1'b1;
         n_term     <= dim_n - 1'b1;
         k_term     <= dim_k - 1'b1;
         n_step     <= OW'(dim_n);
         k_step     <= OW'(dim_k);
         row_base   <= '0;
         beat_a_off <= '0;
         beat_b_off <= '0;
         beat_c_off <= '0;
      end else if (hs) begin
         if (!k_last) begin
            beat_a_off <= beat_a_off + 1'b1;
            beat_b_off <= beat_b_off + n_step;
         end else if (!j_last) begin
            beat_a_off <= row_base;
            beat_b_off <= OW'(beat_j) + OW'(1);
            beat_c_off <= beat_c_off + 1'b1;
         end else if (!i_last) begin
            row_base   <= row_base + k_step;
            beat_a_off <= row_base + k_step;
            beat_b_off <= '0;
            beat_c_off <= beat_c_off + 1'b1;
         end else begin
            row_base   <= '0;
            beat_a_off <= '0;
            beat_b_off <= '0;
            beat_c_off <= '0;
         end
      end
   end

   assign beat_first_k = beat_valid & (beat_k == '0);
   assign beat_last_k  = beat_valid & k_last;

endmodule
